// File: rtl/shift_rotate_if.sv
// Operand/result bundle for shift_rotate.
// master drives en, shiftCount, data, operation; slave returns result, c, valid.
interface shift_rotate_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             en;
    logic [CNT_W-1:0] shiftCount;
    logic [WIDTH-1:0] data;
    logic [1:0]       operation;
    logic [WIDTH-1:0] result;
    logic             c;
    logic             valid;

    modport master (
        output en, shiftCount, data, operation,
        input  result, c, valid
    );

    modport slave (
        input  en, shiftCount, data, operation,
        output result, c, valid
    );
endinterface

// File: rtl/shift_rotate.sv
// Registered shifter/rotator: SHL, SHR, ROL, ROR with carry-out, one-cycle latency.
// Ports: clk, rst (sync, active-high), bus (slave: en, shiftCount, data, operation -> result, c, valid).
// Build option: define SHIFT_ROTATE_ARITH_EN to make operation 01 an arithmetic shift right.
module shift_rotate #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    shift_rotate_if.slave bus
);
    logic [WIDTH:0]       shl_ext;
    logic [WIDTH:0]       shr_ext;
    logic [2*WIDTH-1:0]   rol_ext;
    logic [2*WIDTH-1:0]   ror_ext;
    logic                 nz;
    logic [WIDTH-1:0]     nxt_r;
    logic                 nxt_c;
    logic [WIDTH-1:0]     result_q;
    logic                 c_q;
    logic                 valid_q;

    // The extra guard bit on each shift catches the last bit shifted out,
    // which is exactly the carry; a zero count leaves the guard at zero.
    always_comb begin
        nz      = |bus.shiftCount;
        shl_ext = {1'b0, bus.data} << bus.shiftCount;
`ifdef SHIFT_ROTATE_ARITH_EN
        shr_ext = $unsigned($signed({bus.data, 1'b0}) >>> bus.shiftCount);
`else
        shr_ext = {bus.data, 1'b0} >> bus.shiftCount;
`endif
        // Rotation via a doubled operand: no modular count arithmetic needed.
        rol_ext = {bus.data, bus.data} << bus.shiftCount;
        ror_ext = {bus.data, bus.data} >> bus.shiftCount;
        nxt_r   = '0;
        nxt_c   = 1'b0;
        case (bus.operation)
            2'b00: begin
                nxt_r = shl_ext[WIDTH-1:0];
                nxt_c = shl_ext[WIDTH];
            end
            2'b01: begin
                nxt_r = shr_ext[WIDTH:1];
                nxt_c = shr_ext[0];
            end
            2'b10: begin
                nxt_r = rol_ext[2*WIDTH-1:WIDTH];
                nxt_c = nz & nxt_r[0];
            end
            default: begin
                nxt_r = ror_ext[WIDTH-1:0];
                nxt_c = nz & nxt_r[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            c_q      <= 1'b0;
            valid_q  <= 1'b0;
        end else if (bus.en) begin
            result_q <= nxt_r;
            c_q      <= nxt_c;
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.result = result_q;
    assign bus.c      = c_q;
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_shift_rotate.sv
// Self-checking bench for shift_rotate: bit-level reference model plus directed vectors.
// Compares DUT against the model every cycle and against hand-computed literals.
module tb_shift_rotate;
    localparam int W  = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   armed = 1'b0;

    logic [W-1:0] m_r = '0;
    logic         m_c = 1'b0;
    logic         m_v = 1'b0;

    shift_rotate_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_rotate #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: evaluate each result bit from its source position.
    function automatic logic [W:0] model(input logic [W-1:0] d, input int n,
                                         input logic [1:0] op);
        logic [W-1:0] r;
        logic         cc;
        logic         fill;
        r  = '0;
        cc = 1'b0;
`ifdef SHIFT_ROTATE_ARITH_EN
        fill = d[W-1];
`else
        fill = 1'b0;
`endif
        for (int i = 0; i < W; i++) begin
            case (op)
                2'b00: r[i] = (i >= n) ? d[i-n] : 1'b0;
                2'b01: r[i] = (i + n < W) ? d[i+n] : fill;
                2'b10: r[i] = d[(i - n + W) % W];
                default: r[i] = d[(i + n) % W];
            endcase
        end
        if (n != 0) begin
            case (op)
                2'b00: cc = d[W-n];
                2'b01: cc = d[n-1];
                2'b10: cc = r[0];
                default: cc = r[W-1];
            endcase
        end
        return {cc, r};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_r <= '0;
            m_c <= 1'b0;
            m_v <= 1'b0;
        end else if (bus.en) begin
            {m_c, m_r} <= model(bus.data, int'(bus.shiftCount), bus.operation);
            m_v <= 1'b1;
        end else begin
            m_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({bus.c, bus.result, bus.valid} !== {m_c, m_r, m_v}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got r=%b c=%b v=%b want r=%b c=%b v=%b",
                         $time, bus.result, bus.c, bus.valid, m_r, m_c, m_v);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] r,
                       input logic cc, input logic v);
        checks++;
        if ({bus.result, bus.c, bus.valid} !== {r, cc, v}) begin
            errors++;
            $display("FAIL %s got r=%b c=%b v=%b want r=%b c=%b v=%b",
                     name, bus.result, bus.c, bus.valid, r, cc, v);
        end
    endtask

    task automatic apply(input string name, input logic [W-1:0] d,
                         input logic [CW-1:0] n, input logic [1:0] op,
                         input logic [W-1:0] er, input logic ec);
        @(negedge clk);
        bus.en         = 1'b1;
        bus.data       = d;
        bus.shiftCount = n;
        bus.operation  = op;
        @(posedge clk);
        #1;
        chk(name, er, ec, 1'b1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] d;
        logic [2:0] n;
        logic [1:0] op;
        logic [7:0] er;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"shl_basic", 8'b00000101, 3'd2, 2'b00, 8'b00010100, 1'b0});
        vecs.push_back('{"shl_carry", 8'b01001100, 3'd2, 2'b00, 8'b00110000, 1'b1});
        vecs.push_back('{"rol_carry", 8'b01001100, 3'd2, 2'b10, 8'b00110001, 1'b1});
        vecs.push_back('{"rol_2",     8'b10000110, 3'd2, 2'b10, 8'b00011010, 1'b0});
        vecs.push_back('{"ror_2",     8'b10000110, 3'd2, 2'b11, 8'b10100001, 1'b1});
`ifdef SHIFT_ROTATE_ARITH_EN
        vecs.push_back('{"sar_2",     8'b10000110, 3'd2, 2'b01, 8'b11100001, 1'b1});
`else
        vecs.push_back('{"shr_2",     8'b10000110, 3'd2, 2'b01, 8'b00100001, 1'b1});
`endif
        vecs.push_back('{"shl_zero",  8'b10110011, 3'd0, 2'b00, 8'b10110011, 1'b0});
        vecs.push_back('{"shr_zero",  8'b10110011, 3'd0, 2'b01, 8'b10110011, 1'b0});
        vecs.push_back('{"rol_zero",  8'b10110011, 3'd0, 2'b10, 8'b10110011, 1'b0});
        vecs.push_back('{"ror_zero",  8'b10110011, 3'd0, 2'b11, 8'b10110011, 1'b0});
        vecs.push_back('{"shl_max",   8'b01000011, 3'd7, 2'b00, 8'b10000000, 1'b1});
        vecs.push_back('{"shr_max",   8'b01000011, 3'd7, 2'b01, 8'b00000000, 1'b1});
        vecs.push_back('{"rol_max",   8'b01000011, 3'd7, 2'b10, 8'b10100001, 1'b1});
        vecs.push_back('{"ror_max",   8'b01000011, 3'd7, 2'b11, 8'b10000110, 1'b1});
`ifdef SHIFT_ROTATE_ARITH_EN
        vecs.push_back('{"sar_max",   8'b11000011, 3'd7, 2'b01, 8'b11111111, 1'b1});
`else
        vecs.push_back('{"shr_max_n", 8'b11000011, 3'd7, 2'b01, 8'b00000001, 1'b1});
`endif

        bus.en         = 1'b0;
        bus.data       = '0;
        bus.shiftCount = '0;
        bus.operation  = 2'b00;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 8'h00, 1'b0, 1'b0);
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: en stays high across consecutive vectors.
        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].d, vecs[i].n, vecs[i].op,
                  vecs[i].er, vecs[i].ec);

        // Hold with en low.
        @(negedge clk);
        bus.en   = 1'b0;
        bus.data = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("hold", vecs[vecs.size()-1].er, vecs[vecs.size()-1].ec, 1'b0);
        end

        apply("pre_rst", 8'b10110011, 3'd0, 2'b00, 8'b10110011, 1'b0);

        // Reset together with a valid operand discards it.
        @(negedge clk);
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.data       = 8'b01001100;
        bus.shiftCount = 3'd2;
        bus.operation  = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_over_en", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 8'h00, 1'b0, 1'b0);
        apply("post_rst_op", 8'b00000101, 3'd2, 2'b00, 8'b00010100, 1'b0);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_drop", 8'b00010100, 1'b0, 1'b0);

        @(negedge clk);
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
